dds_frame_bridge: RTL and testbench
===================================

Name: dds_frame_bridge

Overview:
- Parametrised successor of the single-channel host-to-DDS serial path: receives framed serial words from the Rabbit host, buffers them in a FIFO, and replays each frame to one of NUM_CH DDS chips over a shared SPI bus.
- Each replay uses that chip's own chip-select and IO_UPDATE.
- Sits between the host GPIO pins and the DDS serial pins.
- Host and DDS traffic are decoupled, so the host can queue several profile frames ahead.

Parameters:
- FRAME_BITS, 184: payload bits per frame, shifted MSB first.
- NUM_CH, 2: number of DDS chips; CH_BITS = max(1, clog2(NUM_CH)).
- DEPTH, 4: FIFO depth in frames; power of two, at least 2.
- SCLK_DIV, 2: ten_MHz_ext cycles per SCLK half-period; at least 1.
- UPD_CYCLES, 2: IO_UPDATE pulse width in cycles; at least 1.

Ports:
- ten_MHz_ext  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- host_sclk  in  1  host serial clock; asynchronous; at most ten_MHz_ext/8
- host_sdio  in  1  host serial data; sampled on host_sclk rising edge
- host_csb  in  1  host frame strobe, active-low
- pause  in  1  when high, no new frame is started
- sclk  out  1  DDS serial clock; idles low
- sdio  out  1  DDS serial data
- csb_n  out  NUM_CH  per-chip chip-select, active-low
- io_update  out  NUM_CH  per-chip update pulse
- busy  out  1  high while a frame is in flight
- fifo_count  out  clog2(DEPTH)+1  number of frames queued
- overflow  out  1  one-cycle pulse: a complete frame was dropped because the FIFO was full
- frame_err  out  1  one-cycle pulse: a frame had the wrong length (or bad parity, see Optional Feature)

Behaviour:
- Reset:
  - Asynchronous, active-low; these are the only values while reset_n is low.
  - sclk=0, sdio=0, csb_n=all 1, io_update=0, busy=0, fifo_count=0, overflow=0, frame_err=0.
  - FIFO is flushed and any partial host frame is discarded.
  - Reset asserted mid-shift aborts the transfer immediately; no io_update pulse follows.
- Host receive:
  - host_sclk, host_sdio and host_csb each pass through a 2-FF synchroniser.
  - On a synchronised host_sclk rising edge with host_csb low, shift host_sdio into an assembly register and increment the bit count.
  - The host_csb falling edge clears the bit count.
  - On the host_csb rising edge, when count equals CH_BITS+FRAME_BITS: push {ch, payload} if not full, else pulse overflow.
  - On any other count: pulse frame_err and push nothing.
  - Frame layout: CH_BITS channel field first (MSB first), then payload MSB first.
  - A channel field of NUM_CH or above is a frame_err.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Push when full is refused, with overflow pulsed in the cycle after host_csb rises.
- Output FSM:
  - IDLE: go to LOAD when the FIFO is non-empty and pause=0.
  - LOAD (1 cycle): pop the FIFO, latch ch and payload, drive csb_n[ch]=0 and sdio=payload MSB, set busy=1.
  - SHIFT: each bit is SCLK_DIV cycles of sclk=0 followed by SCLK_DIV cycles of sclk=1. sdio changes only on sclk falling edges, so DDS samples on rising edges. After FRAME_BITS bits, go to DESELECT.
  - DESELECT (1 cycle): sclk=0, csb_n all 1, sdio=0.
  - UPDATE: io_update[ch]=1 for UPD_CYCLES cycles, then return to IDLE with busy=0.
  - Frame latency, LOAD to the end of UPDATE: 1 + 2*SCLK_DIV*FRAME_BITS + 1 + UPD_CYCLES cycles.
  - pause going high mid-frame does not interrupt the frame; it only blocks the next LOAD.
  - Back-to-back frames: LOAD follows UPDATE directly, so csb_n is high for at least 1+UPD_CYCLES cycles between frames.
  - At most one csb_n bit is low and at most one io_update bit is high at any time.

Optional Feature:
- Macro: DDS_FRAME_PARITY_EN.
- With the macro defined:
  - The host appends one even-parity bit after the payload; the expected length becomes CH_BITS+FRAME_BITS+1.
  - A parity mismatch pulses frame_err and nothing is pushed.
  - The parity bit is not stored.
- Without the macro: no parity bit is expected and no parity logic is built.

Decomposition:
- Package dds_bridge_pkg holds:
  - localparams CH_BITS, ENTRY_BITS (= CH_BITS+FRAME_BITS) and CNT_BITS;
  - the FSM state enum {IDLE, LOAD, SHIFT, DESELECT, UPDATE};
  - the parity helper function.
- Sub-module host_frame_rx contains the synchronisers, assembly register, bit counter, length/parity check and push strobe.
- The FIFO and output FSM stay in the top module.

Test Plan (NUM_CH=2, FRAME_BITS=184, SCLK_DIV=2, UPD_CYCLES=2, DEPTH=4):
- Single frame, ch=1, payload 184'h00...A5 → csb_n=2'b01; 184 sclk rises; the last 8 sampled bits are 10100101; io_update[1] high for 2 cycles; total 1+736+1+2=740 cycles; busy falls afterwards.
- 183-bit host frame → frame_err pulses once, fifo_count stays 0, no DDS activity.
- pause=1 while 5 frames are sent → fifo_count=4, overflow pulses once; after pause=0, exactly 4 frames are replayed in order.
- reset_n pulled low at bit 90 of a shift → outputs go to reset values in the same cycle, no io_update; after release, fifo_count=0.
- Frames ch=0 then ch=1 → csb_n sequence 10 then 01, never 00; io_update[0] precedes io_update[1].
- With DDS_FRAME_PARITY_EN defined: a good-parity frame is replayed; the same frame with its parity bit flipped gives frame_err and is not replayed.

Source files
------------

// File: rtl/dds_bridge_pkg.sv
// Shared types and sizing helpers for the host-to-DDS frame bridge.
// The optional even-parity check is enabled with DDS_FRAME_PARITY_EN.
package dds_bridge_pkg;

  localparam int DEF_FRAME_BITS = 184;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_DEPTH      = 4;

  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_BITS    = ch_bits(DEF_NUM_CH);
  localparam int ENTRY_BITS = CH_BITS + DEF_FRAME_BITS;
  localparam int CNT_BITS   = $clog2(DEF_DEPTH) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DESELECT, UPDATE} out_state_t;

  // Running parity: fold one received bit into the accumulator.
  function automatic logic par_step(input logic acc, input logic b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/host_frame_rx.sv
// Host-side receiver: synchronises the host serial pins, assembles one frame
// per host_csb strobe and emits a push strobe or a frame error.
// Parity bit handling is built only when DDS_FRAME_PARITY_EN is defined.
module host_frame_rx
  import dds_bridge_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int NUM_CH     = DEF_NUM_CH,
  localparam int CH_W      = ch_bits(NUM_CH),
  localparam int ENTRY_W   = CH_W + FRAME_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_sclk,
  input  logic               host_sdio,
  input  logic               host_csb,
  output logic               frame_vld,
  output logic [ENTRY_W-1:0] frame_data,
  output logic               frame_err
);

`ifdef DDS_FRAME_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int LEN  = ENTRY_W + PAR_W;
  localparam int BC_W = $clog2(LEN + 2);

  logic [1:0]         sclk_s, sdio_s, csb_s;
  logic               sclk_d, csb_d;
  logic               shift_en, csb_fall, csb_rise;
  logic [LEN-1:0]     asm_q;
  logic [BC_W-1:0]    bcnt;
  logic [ENTRY_W-1:0] entry;
  logic [CH_W:0]      ch_field;
  logic               len_ok, ch_ok, par_ok, frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      sdio_s <= '0;
      csb_s  <= '1;
      sclk_d <= 1'b0;
      csb_d  <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[0], host_sclk};
      sdio_s <= {sdio_s[0], host_sdio};
      csb_s  <= {csb_s[0], host_csb};
      sclk_d <= sclk_s[1];
      csb_d  <= csb_s[1];
    end
  end

  assign shift_en = sclk_s[1] & ~sclk_d & ~csb_s[1];
  assign csb_fall = ~csb_s[1] & csb_d;
  assign csb_rise = csb_s[1] & ~csb_d;

  // Counter saturates so an over-long frame can never wrap back to a legal length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      bcnt  <= '0;
    end else begin
      if (shift_en) asm_q <= {asm_q[LEN-2:0], sdio_s[1]};
      if (csb_fall)                      bcnt <= '0;
      else if (shift_en && bcnt != '1)   bcnt <= bcnt + 1'b1;
    end
  end

`ifdef DDS_FRAME_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        par_q <= 1'b0;
    else if (csb_fall) par_q <= 1'b0;
    else if (shift_en) par_q <= par_step(par_q, sdio_s[1]);
  end
  assign par_ok = ~par_q;
  assign entry  = asm_q[LEN-1:1];
`else
  assign par_ok = 1'b1;
  assign entry  = asm_q;
`endif

  assign ch_field = {1'b0, entry[ENTRY_W-1 -: CH_W]};
  assign ch_ok    = ch_field < (CH_W+1)'(NUM_CH);
  assign len_ok   = bcnt == BC_W'(LEN);
  assign frame_ok = len_ok & ch_ok & par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_vld  <= 1'b0;
      frame_err  <= 1'b0;
      frame_data <= '0;
    end else begin
      frame_vld <= csb_rise & frame_ok;
      frame_err <= csb_rise & ~frame_ok;
      if (csb_rise) frame_data <= entry;
    end
  end

endmodule

// File: rtl/dds_frame_bridge.sv
// Host-to-DDS frame bridge: queues host frames in a FIFO and replays each one
// to the addressed DDS chip over a shared SPI bus followed by an IO_UPDATE pulse.
// Define DDS_FRAME_PARITY_EN to require an even-parity bit on host frames.
module dds_frame_bridge
  import dds_bridge_pkg::*;
#(
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SCLK_DIV   = 2,
  parameter int UPD_CYCLES = 2
) (
  input  logic                   ten_MHz_ext,
  input  logic                   reset_n,
  input  logic                   host_sclk,
  input  logic                   host_sdio,
  input  logic                   host_csb,
  input  logic                   pause,
  output logic                   sclk,
  output logic                   sdio,
  output logic [NUM_CH-1:0]      csb_n,
  output logic [NUM_CH-1:0]      io_update,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   frame_err
);

  localparam int CH_W    = ch_bits(NUM_CH);
  localparam int ENTRY_W = CH_W + FRAME_BITS;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DIV_W   = $clog2(2 * SCLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int UPD_W   = $clog2(UPD_CYCLES + 1);

  logic               rx_vld;
  logic [ENTRY_W-1:0] rx_data;

  host_frame_rx #(.FRAME_BITS(FRAME_BITS), .NUM_CH(NUM_CH)) u_rx (
    .clk        (ten_MHz_ext),
    .rst_n      (reset_n),
    .host_sclk  (host_sclk),
    .host_sdio  (host_sdio),
    .host_csb   (host_csb),
    .frame_vld  (rx_vld),
    .frame_data (rx_data),
    .frame_err  (frame_err)
  );

  // ---------------- frame FIFO ----------------
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               full, push, pop;
  logic [ENTRY_W-1:0] head;
  logic [CH_W-1:0]    head_ch;
  logic [FRAME_BITS-1:0] head_pl;

  assign full    = cnt == CNT_W'(DEPTH);
  assign push    = rx_vld & ~full;
  assign head    = mem[rd_ptr];
  assign head_ch = head[ENTRY_W-1 -: CH_W];
  assign head_pl = head[FRAME_BITS-1:0];
  assign fifo_count = cnt;

  always_ff @(posedge ten_MHz_ext) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge ten_MHz_ext or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= rx_vld & full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------- output FSM ----------------
  out_state_t            state, nxt;
  logic [FRAME_BITS-1:0] shreg;
  logic [CH_W-1:0]       ch_q, sel_ch;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [UPD_W-1:0]      upd_cnt;
  logic                  can_start, bit_end;

  assign can_start = (cnt != '0) & ~pause;
  assign bit_end   = div_cnt == DIV_W'(2 * SCLK_DIV - 1);
  assign pop       = state == LOAD;

  always_ff @(posedge ten_MHz_ext or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt    = state;
    sel_ch = ch_q;
    sclk   = 1'b0;
    sdio   = 1'b0;
    busy   = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (can_start) nxt = LOAD;
      end
      LOAD: begin
        nxt    = SHIFT;
        sel_ch = head_ch;
        sdio   = head_pl[FRAME_BITS-1];
      end
      SHIFT: begin
        sclk = div_cnt >= DIV_W'(SCLK_DIV);
        sdio = shreg[FRAME_BITS-1];
        if (bit_end && bit_cnt == BIT_W'(FRAME_BITS - 1)) nxt = DESELECT;
      end
      DESELECT: nxt = UPDATE;
      UPDATE: begin
        // Chain straight into the next LOAD so queued frames go back to back.
        if (upd_cnt == UPD_W'(UPD_CYCLES - 1)) nxt = can_start ? LOAD : IDLE;
      end
      default: begin
        nxt  = IDLE;
        busy = 1'b0;
      end
    endcase
  end

  // sdio follows shreg, which only moves as sclk drops from high to low.
  always_ff @(posedge ten_MHz_ext or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      ch_q    <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      upd_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg   <= head_pl;
          ch_q    <= head_ch;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (bit_end) begin
            div_cnt <= '0;
            shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DESELECT: upd_cnt <= '0;
        UPDATE:   upd_cnt <= upd_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign csb_n[i]     = ~(((state == LOAD) || (state == SHIFT)) && (sel_ch == CH_W'(i)));
    assign io_update[i] = (state == UPDATE) && (ch_q == CH_W'(i));
  end

endmodule

// File: tb/tb_dds_frame_bridge.sv
// Directed/randomised bench for dds_frame_bridge: a host driver, a DDS pin
// monitor and a frame-level reference model of what should be replayed.
module tb_dds_frame_bridge;

  localparam int FB = 184;
  localparam int NC = 2;
  localparam int DP = 4;
`ifdef DDS_FRAME_PARITY_EN
  localparam int LEN = 1 + FB + 1;
`else
  localparam int LEN = 1 + FB;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic host_sclk = 1'b0, host_sdio = 1'b0, host_csb = 1'b1, pause = 1'b0;
  logic sclk, sdio, busy, overflow, frame_err;
  logic [NC-1:0] csb_n, io_update;
  logic [2:0] fifo_count;

  dds_frame_bridge #(.FRAME_BITS(FB), .NUM_CH(NC), .DEPTH(DP), .SCLK_DIV(2), .UPD_CYCLES(2)) dut (
    .ten_MHz_ext(clk), .reset_n(reset_n), .host_sclk(host_sclk), .host_sdio(host_sdio),
    .host_csb(host_csb), .pause(pause), .sclk(sclk), .sdio(sdio), .csb_n(csb_n),
    .io_update(io_update), .busy(busy), .fifo_count(fifo_count), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #50 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- DDS pin monitor ----------------
  typedef struct {
    logic [FB:0] data;
    int          bits;
    int          upd_len;
    int          upd_ch;
  } obs_t;
  obs_t obs_q[$];

  logic          sclk_d = 1'b0, busy_d = 1'b0, cap_ch = 1'b0, cs_bad = 1'b0;
  logic [FB-1:0] cap = '0;
  int cap_bits = 0, upd_len = 0, upd_ch = 0;
  int err_cnt = 0, ovf_cnt = 0, busy_rises = 0, busy_run = 0, busy_len = 0;

  always @(negedge clk) begin
    sclk_d <= sclk;
    busy_d <= busy;
    if ($countones(~csb_n) > 1 || $countones(io_update) > 1) cs_bad <= 1'b1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (overflow)  ovf_cnt <= ovf_cnt + 1;
    if (busy && !busy_d) begin
      busy_rises <= busy_rises + 1;
      busy_run   <= 1;
    end else if (busy) busy_run <= busy_run + 1;
    if (!busy && busy_d) busy_len <= busy_run;
    if (!reset_n) begin
      cap_bits <= 0;
      upd_len  <= 0;
    end else begin
      if (sclk && !sclk_d && csb_n != '1) begin
        cap      <= {cap[FB-2:0], sdio};
        cap_bits <= cap_bits + 1;
        cap_ch   <= csb_n[0];
      end
      if (io_update != '0) begin
        upd_len <= upd_len + 1;
        upd_ch  <= io_update[1] ? 1 : 0;
      end else if (upd_len != 0) begin
        obs_q.push_back('{data: {cap_ch, cap}, bits: cap_bits, upd_len: upd_len, upd_ch: upd_ch});
        cap_bits <= 0;
        upd_len  <= 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [FB:0] exp_q[$];
  int m_err = 0, m_ovf = 0, m_held = 0;

  // Host drives bits MSB first, one bit per 8 system clocks.
  task automatic host_send(input int n, input logic [255:0] v);
    @(negedge clk); host_csb = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      host_sdio = v[i];
      repeat (4) @(negedge clk); host_sclk = 1'b1;
      repeat (4) @(negedge clk); host_sclk = 1'b0;
    end
    repeat (4) @(negedge clk); host_csb = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Sends one frame and records what the spec says must happen to it.
  // With pause low the replay (740 cycles) outruns the host (~1500 cycles/frame),
  // so only frames sent while paused accumulate in the queue.
  task automatic send_frame(input logic ch, input logic [FB-1:0] pl, input bit short_len, input bit flip_par);
    logic [FB:0]   entry;
    logic [255:0]  v;
    int            n;
    entry = {ch, pl};
`ifdef DDS_FRAME_PARITY_EN
    v = {70'd0, entry, (^entry) ^ flip_par};
`else
    v = {71'd0, entry};
`endif
    n = LEN;
    if (short_len) begin
      v = v >> 1;
      n = LEN - 1;
    end
    host_send(n, v);
    if (short_len || flip_par) m_err++;
    else if (m_held == DP) m_ovf++;
    else begin
      exp_q.push_back(entry);
      if (pause) m_held++;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (!busy && fifo_count == 3'd0) ok = 1'b1;
    end
    check({tag, "_drain_timeout"}, ok, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_replays(input string tag);
    logic [FB:0] e;
    obs_t        o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing"}, 0, 1);
      end else begin
        o = obs_q.pop_front();
        check({tag, "_data"}, o.data, e);
        check({tag, "_bits"}, o.bits, FB);
        check({tag, "_upd_len"}, o.upd_len, 2);
        check({tag, "_upd_ch"}, o.upd_ch, e[FB]);
      end
    end
    check({tag, "_extra"}, obs_q.size(), 0);
  endtask

  function automatic logic [FB-1:0] rnd_payload();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    return r[FB-1:0];
  endfunction

  initial begin
    logic [FB-1:0] pl;
    int rises0, err0;
    bit hit;

    // reset values while reset_n is low
    repeat (5) @(negedge clk);
    check("rst_pins", {sclk, sdio, csb_n, io_update}, 6'b00_11_00);
    check("rst_stat", {busy, fifo_count, overflow, frame_err}, 6'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // single frame ch=1, payload A5
    pl = '0; pl[7:0] = 8'hA5;
    send_frame(1'b1, pl, 1'b0, 1'b0);
    wait_idle("single");
    check("single_busy_len", busy_len, 740);
    check("single_last8", obs_q.size() > 0 ? obs_q[0].data[7:0] : 8'h00, 8'hA5);
    check_replays("single");

    // 183-bit frame: error only, nothing replayed
    rises0 = busy_rises;
    send_frame(1'b0, rnd_payload(), 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("short_err", err_cnt, m_err);
    check("short_count", fifo_count, 3'd0);
    check("short_no_busy", busy_rises, rises0);

    // ch=0 then ch=1 with random payloads
    send_frame(1'b0, rnd_payload(), 1'b0, 1'b0);
    send_frame(1'b1, rnd_payload(), 1'b0, 1'b0);
    wait_idle("pair");
    check_replays("pair");

    // five frames while paused: four held, one overflow
    pause = 1'b1;
    rises0 = busy_rises;
    for (int k = 0; k < 5; k++) send_frame(1'($urandom_range(0, 1)), rnd_payload(), 1'b0, 1'b0);
    check("pause_count", fifo_count, 3'd4);
    check("pause_ovf", ovf_cnt, m_ovf);
    check("pause_no_busy", busy_rises, rises0);
    pause = 1'b0;
    m_held = 0;
    wait_idle("pause");
    check_replays("pause");

    // reset in the middle of a shift
    send_frame(1'($urandom_range(0, 1)), rnd_payload(), 1'b0, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      @(posedge clk);
      if (cap_bits == 90) hit = 1'b1;
    end
    check("midrst_reach90", hit, 1'b1);
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("midrst_pins", {sclk, sdio, csb_n, io_update}, 6'b00_11_00);
    check("midrst_stat", {busy, fifo_count, overflow, frame_err}, 6'b0);
    exp_q.delete();
    repeat (3) @(negedge clk); reset_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("midrst_count", fifo_count, 3'd0);
    check("midrst_no_upd", obs_q.size(), 0);

`ifdef DDS_FRAME_PARITY_EN
    pl = rnd_payload();
    err0 = err_cnt;
    send_frame(1'b0, pl, 1'b0, 1'b0);
    wait_idle("par_good");
    check_replays("par_good");
    send_frame(1'b0, pl, 1'b0, 1'b1);
    wait_idle("par_bad");
    check("par_bad_err", err_cnt - err0, 1);
    check_replays("par_bad");
`else
    err0 = 0;
`endif

    check("final_err", err_cnt, m_err);
    check("final_ovf", ovf_cnt, m_ovf);
    check("cs_onehot", cs_bad, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
